// File: rtl/add_seq_pkg.sv
// Shared constants for the nibble-serial add/sub sequencer.
// State encoding and the slice width.
package add_seq_pkg;

    localparam int NIBW = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/nibble_add_dp.sv
// Shared 4-bit PG/GG carry-lookahead slice with operand nibble mux.
// Produces the nibble sum, the carry to the next nibble and c[3].
module nibble_add_dp
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IW    = 3
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [IW-1:0]    idx_i,
    input  logic             carry_i,
    output logic [NIBW-1:0]  nib_sum_o,
    output logic             carry_next_o,
    output logic             c_msb_o
);

    logic [NIBW-1:0] an;
    logic [NIBW-1:0] bn;
    logic [NIBW-1:0] p;
    logic [NIBW-1:0] g;
    logic [NIBW-1:0] c;
    logic            pg;
    logic            gg;

    assign an = a_i[NIBW*idx_i +: NIBW];
    assign bn = b_i[NIBW*idx_i +: NIBW];
    assign p  = an ^ bn;
    assign g  = an & bn;

    // Lookahead carries inside the slice and group propagate/generate
    always_comb begin
        c[0] = carry_i;
        c[1] = g[0] | (p[0] & carry_i);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_i);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & carry_i);
        pg   = &p;
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    end

    assign nib_sum_o    = p ^ c;
    assign carry_next_o = gg | (pg & carry_i);
    assign c_msb_o      = c[3];

endmodule

// File: rtl/add_nibble_seq.sv
// Multi-cycle WIDTH-bit add/sub, one nibble per cycle through one slice.
// FSM, nibble index, carry and result registers live here.
module add_nibble_seq
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB = WIDTH / NIBW;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [NIBW-1:0]  nib_sum;
    logic             carry_d;
    logic             c_msb;

    nibble_add_dp #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_dp (
        .a_i          (a_q),
        .b_i          (b_q),
        .idx_i        (idx_q),
        .carry_i      (carry_q),
        .nib_sum_o    (nib_sum),
        .carry_next_o (carry_d),
        .c_msb_o      (c_msb)
    );

    // Sequencer: accept, walk nibbles, hold result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid && !abort) begin
                        a_q        <= a;
                        b_q        <= b ^ {WIDTH{sub}};
                        carry_q    <= sub ? 1'b1 : cin;
                        idx_q      <= '0;
                        sum_q      <= '0;
                        cout_q     <= 1'b0;
                        ovf_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        sum_q      <= '0;
                        cout_q     <= 1'b0;
                        ovf_q      <= 1'b0;
                        carry_q    <= 1'b0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        sum_q[NIBW*idx_q +: NIBW] <= nib_sum;
                        carry_q <= carry_d;
                        idx_q   <= idx_q + 1'b1;
                        if (idx_q == LAST) begin
                            cout_q      <= carry_d;
                            ovf_q       <= c_msb ^ carry_d;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (abort) begin
                        sum_q       <= '0;
                        cout_q      <= 1'b0;
                        ovf_q       <= 1'b0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        carry_q     <= 1'b0;
                        idx_q       <= '0;
                        state_q     <= S_IDLE;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        carry_q     <= 1'b0;
                        idx_q       <= '0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_nibble_seq.sv
// Bench for add_nibble_seq: directed cases plus random ops.
// Reference is plain 32-bit arithmetic with signed-overflow rules.
module tb_add_nibble_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    add_nibble_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input  logic [31:0] x,
                                  input  logic [31:0] y,
                                  input  logic        ci,
                                  input  logic        s,
                                  output logic [31:0] r,
                                  output logic        co,
                                  output logic        ov);
        logic [32:0] t;
        if (s) begin
            r  = x - y;
            co = (x >= y);
            ov = (x[31] != y[31]) && (r[31] != x[31]);
        end else begin
            t  = {1'b0, x} + {1'b0, y} + {32'd0, ci};
            r  = t[31:0];
            co = t[32];
            ov = (x[31] == y[31]) && (r[31] != x[31]);
        end
    endfunction

    task automatic present(input logic [31:0] x, input logic [31:0] y,
                           input logic ci, input logic s);
        int k = 0;
        while (!in_ready && k < 20) begin
            step();
            k++;
        end
        chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
        a = x;
        b = y;
        cin = ci;
        sub = s;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input string tag,
                            input logic [31:0] x, input logic [31:0] y,
                            input logic ci, input logic s);
        logic [31:0] r;
        logic        co;
        logic        ov;
        int          n = 1;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        model(x, y, ci, s, r, co, ov);
        chk({tag, ".lat"}, 64'(n), 64'd9);
        chk({tag, ".sum"}, {32'd0, sum}, {32'd0, r});
        chk({tag, ".cout"}, {63'd0, cout}, {63'd0, co});
        chk({tag, ".ovf"}, {63'd0, ovf}, {63'd0, ov});
    endtask

    task automatic take(input int hold);
        out_ready = 1'b0;
        repeat (hold) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("take.in_ready", {63'd0, in_ready}, 64'd1);
        chk("take.out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic run_op(input string tag,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic ci, input logic s, input int hold);
        present(x, y, ci, s);
        wait_res(tag, x, y, ci, s);
        take(hold);
    endtask

    initial begin
        logic [31:0] r1;
        logic        c1;
        logic        o1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        #7;
        chk("rst.in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst.sum", {32'd0, sum}, 64'd0);
        chk("rst.cout", {63'd0, cout}, 64'd0);
        chk("rst.ovf", {63'd0, ovf}, 64'd0);
        rst_n = 1'b1;
        step();

        run_op("chain", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        run_op("sub1", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0);
        run_op("sub2", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0);
        run_op("wrap", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);
        run_op("addovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1);

        present(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        wait_res("bp", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp.out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp.sum", {32'd0, sum}, 64'h2345_6789);
            chk("bp.in_ready", {63'd0, in_ready}, 64'd0);
        end
        take(0);

        present(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        repeat (3) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abrt.out_valid", {63'd0, out_valid}, 64'd0);
        chk("abrt.in_ready", {63'd0, in_ready}, 64'd1);
        chk("abrt.sum", {32'd0, sum}, 64'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("abrt.no_valid", {63'd0, out_valid}, 64'd0);
        end

        present(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_res("abd", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abd.out_valid", {63'd0, out_valid}, 64'd0);
        chk("abd.cout", {63'd0, cout}, 64'd0);
        chk("abd.in_ready", {63'd0, in_ready}, 64'd1);

        a = 32'd9;
        b = 32'd9;
        in_valid = 1'b1;
        abort = 1'b1;
        step();
        in_valid = 1'b0;
        abort = 1'b0;
        chk("abi.in_ready", {63'd0, in_ready}, 64'd1);
        repeat (10) step();
        chk("abi.out_valid", {63'd0, out_valid}, 64'd0);

        present(32'h7777_7777, 32'h1111_1111, 1'b0, 1'b0);
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.sum", {32'd0, sum}, 64'd0);
        chk("arst.in_ready", {63'd0, in_ready}, 64'd1);
        chk("arst.out_valid", {63'd0, out_valid}, 64'd0);
        #3;
        rst_n = 1'b1;
        step();
        run_op("post", 32'd1, 32'd2, 1'b0, 1'b0, 0);

        present(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);
        wait_res("b2b1", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);
        model(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0, r1, c1, o1);
        a = 32'h0000_0010;
        b = 32'h0000_0020;
        cin = 1'b0;
        sub = 1'b1;
        in_valid = 1'b1;
        repeat (2) step();
        chk("b2b.hold_sum", {32'd0, sum}, {32'd0, r1});
        chk("b2b.in_ready", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("b2b.idle", {63'd0, in_ready}, 64'd1);
        chk("b2b.drop", {63'd0, out_valid}, 64'd0);
        step();
        in_valid = 1'b0;
        chk("b2b.accepted", {63'd0, in_ready}, 64'd0);
        wait_res("b2b2", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1);
        take(0);

        for (int i = 0; i < 30; i++) begin
            run_op("rnd", $urandom, $urandom,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
